// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port among ALU, load and link-register writeback sources.
// One-cycle registered grant; requesters are held off by withholding ack (LR fixed priority, ALU/MEM round-robin).
module regfile_wb_arbiter #(
  parameter int W       = 32,
  parameter int A       = 3,
  parameter int LR_ADDR = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         alu_req,
  input  logic [A-1:0] alu_addr,
  input  logic [W-1:0] alu_data,
  output logic         alu_ack,
  input  logic         mem_req,
  input  logic [A-1:0] mem_addr,
  input  logic [W-1:0] mem_data,
  output logic         mem_ack,
  input  logic         lr_req,
  input  logic [W-1:0] lr_data,
  output logic         lr_ack,
  output logic         rf_we,
  output logic         rf_lrwrite,
  output logic [A-1:0] rf_add3,
  output logic [W-1:0] rf_in,
  output logic [15:0]  conflict_cnt
);

  localparam logic [A-1:0] LR_A = A'(LR_ADDR);

  logic elig_alu, elig_mem, elig_lr;
  logic gnt_alu, gnt_mem, gnt_lr;
  logic conflict;
  // Set when MEM won the most recent ALU/MEM grant, so ALU wins the next tie.
  logic last_mem;

  // A source acked this cycle is masked so a held request is not granted twice.
  assign elig_alu = alu_req & ~alu_ack;
  assign elig_mem = mem_req & ~mem_ack;
  assign elig_lr  = lr_req  & ~lr_ack;

  always_comb begin
    gnt_lr   = elig_lr;
    gnt_alu  = 1'b0;
    gnt_mem  = 1'b0;
    conflict = 1'b0;
    if (!elig_lr) begin
      gnt_alu = elig_alu & (~elig_mem | last_mem);
      gnt_mem = elig_mem & (~elig_alu | ~last_mem);
    end
    conflict = (elig_alu & elig_mem) | (elig_lr & (elig_alu | elig_mem));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_ack      <= 1'b0;
      mem_ack      <= 1'b0;
      lr_ack       <= 1'b0;
      rf_we        <= 1'b0;
      rf_lrwrite   <= 1'b0;
      rf_add3      <= '0;
      rf_in        <= '0;
      conflict_cnt <= '0;
      last_mem     <= 1'b1;
    end else begin
      alu_ack    <= gnt_alu;
      mem_ack    <= gnt_mem;
      lr_ack     <= gnt_lr;
      rf_we      <= gnt_alu | gnt_mem;
      rf_lrwrite <= gnt_lr;
      if (gnt_lr) begin
        rf_add3 <= LR_A;
        rf_in   <= lr_data;
      end else if (gnt_alu) begin
        rf_add3 <= alu_addr;
        rf_in   <= alu_data;
      end else if (gnt_mem) begin
        rf_add3 <= mem_addr;
        rf_in   <= mem_data;
      end else begin
        rf_add3 <= '0;
        rf_in   <= '0;
      end
      if (gnt_alu)
        last_mem <= 1'b0;
      else if (gnt_mem)
        last_mem <= 1'b1;
      if (conflict && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single write port of the register file (write enable, link-register write, destination address, write data) between three writeback sources of the multicycle processor: ALU result, memory load data and link-register save.
Sits between the control/datapath writeback sources and the register file. Drives the register file's write-side inputs from registers.
Uses a fixed-priority plus round-robin scheme and a req/ack handshake so that no source can starve and no write is ever lost or duplicated.

Parameters:
W, 32, data width of register file write data
A, 3, register address width (8 registers)
LR_ADDR, 7, address driven on rf_add3 for link-register writes

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
alu_req  input  1  ALU writeback request, held until acked
alu_addr  input  A  ALU destination register
alu_data  input  W  ALU result
alu_ack  output  1  one-cycle grant pulse for ALU request
mem_req  input  1  load writeback request, held until acked
mem_addr  input  A  load destination register
mem_data  input  W  load data
mem_ack  output  1  one-cycle grant pulse for load request
lr_req  input  1  link-register save request, held until acked
lr_data  input  W  return address to save
lr_ack  output  1  one-cycle grant pulse for LR request
rf_we  output  1  to register file write enable
rf_lrwrite  output  1  to register file LRWrite
rf_add3  output  A  to register file write address
rf_in  output  W  to register file write data
conflict_cnt  output  16  saturating count of contended cycles

Behaviour:
- Reset: all outputs 0, conflict_cnt=0, round-robin pointer set so the ALU wins the next ALU/MEM tie. Applies on any rising edge with rst=1, including mid-operation.
- Reset mid-operation: an in-flight grant is dropped with no ack issued. Requesters must re-present their request after reset.
- Eligibility in cycle t: x_req=1 and x_ack=0 in cycle t. A source being acked this cycle is masked, so a held req is never granted twice.
- Priority among eligible sources: LR first (fixed). Then ALU vs MEM round-robin: when both are eligible, grant the one not granted most recently among the two. The pointer updates only on ALU or MEM grants; LR grants leave it unchanged.
- Latency: the grant decision in cycle t is registered. In cycle t+1 the write outputs and the matching x_ack are valid for exactly one cycle. The register file writes at the end of cycle t+1.
- Write-port encoding in cycle t+1:
  - ALU grant: rf_we=1, rf_lrwrite=0, rf_add3=alu_addr, rf_in=alu_data (values sampled at end of cycle t).
  - MEM grant: same, using the mem_* signals.
  - LR grant: rf_we=0, rf_lrwrite=1, rf_add3=LR_ADDR, rf_in=lr_data.
  - No grant: rf_we=0, rf_lrwrite=0, rf_add3=0, rf_in=0.
- Requester rule: hold req, addr and data stable from assertion through the cycle ack=1. Req may be deasserted, or a new request presented, from the cycle after ack.
- Throughput: at most one write per cycle overall. A single source alone gets one write every 2 cycles because of ack masking.
- At most one ack is high in any cycle. Acks are mutually exclusive with each other and coincident with the write they acknowledge.
- Same destination from ALU and MEM: writes are issued in grant order with no merging. The later grant's data ends up in the register.
- conflict_cnt: increments by 1 in each non-reset cycle with at least 2 eligible sources. It saturates at 16'hFFFF and does not wrap.
- Req deasserted before ack (protocol violation): no ack is owed if the source was not granted. If the source was already granted, the write still completes with the sampled values.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, no reqs -> all outputs 0, conflict_cnt=0.
- Single ALU request: alu_req=1, alu_addr=3, alu_data=32'h0000_00AA at cycle t -> cycle t+1 rf_we=1, rf_add3=3, rf_in=AA, alu_ack=1. Next cycle no regrant even with req still high.
- ALU and MEM both held for 6 cycles after reset, addr 2 and 5 -> grants alternate ALU, MEM, ALU, MEM. One write per cycle. conflict_cnt increments only in cycles where both are eligible.
- LR priority: lr_req, alu_req and mem_req asserted together, lr_data=32'h0000_0040 -> first write rf_lrwrite=1, rf_we=0, rf_add3=7, rf_in=40, lr_ack=1. Next write goes to ALU.
- Same-address collision: ALU writes 1 and MEM writes 2 to addr 4, ALU favored -> writes issued in order ALU then MEM. The register file reads back 2 at addr 4.
- Reset mid-grant: assert rst in the cycle after a grant decision -> no ack, no rf_we. Outputs are 0 and conflict_cnt=0 the following cycle. Re-requesting succeeds after reset.
